// File: rtl/width_pkg.sv
`default_nettype none
// ============================================================================
// Module   : width_pkg
// Brief    : Shared defaults and lane-mask helper for the width upsizer.
// Revision : 1.0 - initial release
// ============================================================================
package width_pkg;

  localparam int DEFAULT_IN_W  = 8;
  localparam int DEFAULT_RATIO = 4;
  localparam int MAX_RATIO     = 16;

  // Mask with bits 0..n set; callers slice it down to their own lane count.
  function automatic logic [MAX_RATIO-1:0] lane_mask(input logic [3:0] n);
    logic [MAX_RATIO-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_RATIO; i++) begin
      m[i] = (4'(i) <= n);
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/width_upsizer.sv
`default_nettype none
// ============================================================================
// Module   : width_upsizer
// Brief    : Packs RATIO narrow beats into one wide word, little-endian,
//            with early flush on in_last and a per-lane keep mask.
// Revision : 1.0 - initial release
// ============================================================================
module width_upsizer
  import width_pkg::*;
#(
  parameter int IN_W  = DEFAULT_IN_W,
  parameter int RATIO = DEFAULT_RATIO
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IN_W*RATIO-1:0] out_data,
  output logic [RATIO-1:0]      out_keep,
  output logic                  out_last
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int CNT_W = $clog2(RATIO);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [RATIO-1:0] out_keep_q, out_keep_d;
  logic             out_last_q, out_last_d;

  logic                 in_fire;
  logic                 out_fire;
  logic                 complete;
  logic [OUT_W-1:0]     acc_next;
  logic [MAX_RATIO-1:0] full_mask;

  assign in_ready = !out_valid_q || out_ready;

  always_comb begin
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid_q && out_ready;
    complete  = in_fire && ((cnt_q == LAST_LANE) || in_last);
    full_mask = lane_mask(4'(cnt_q));

    acc_next = acc_q;
    for (int i = 0; i < RATIO; i++) begin
      if (CNT_W'(i) == cnt_q) begin
        acc_next[i*IN_W +: IN_W] = in_data;
      end
    end

    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;

    if (out_fire) begin
      out_valid_d = 1'b0;
    end

    // A completing beat may land on the same edge the old word leaves.
    // The accumulator is cleared on every emit so unused lanes read as zero.
    if (complete) begin
      out_valid_d = 1'b1;
      out_data_d  = acc_next;
      out_keep_d  = full_mask[RATIO-1:0];
      out_last_d  = in_last;
      cnt_d       = '0;
      acc_d       = '0;
    end else if (in_fire) begin
      acc_d = acc_next;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_last  = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_width_upsizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_width_upsizer
// Brief    : Scoreboard bench for width_upsizer (IN_W=8, RATIO=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_width_upsizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          words    = 0;
  int          stalls   = 0;
  int          m_cnt    = 0;
  logic [31:0] m_acc    = '0;

  width_upsizer #(.IN_W(8), .RATIO(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: a transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      words++;
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 64'(sb.size()), 64'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("out_data", 64'(out_data), 64'(e.data));
        check_eq("out_keep", 64'(out_keep), 64'(e.keep));
        check_eq("out_last", 64'(out_last), 64'(e.last));
      end
    end
  end

  task automatic model_accept(input logic [7:0] d, input logic l);
    exp_t e;
    m_acc[m_cnt*8 +: 8] = d;
    if (m_cnt == 3 || l) begin
      e.data = m_acc;
      e.keep = 4'((1 << (m_cnt + 1)) - 1);
      e.last = l;
      sb.push_back(e);
      m_acc = '0;
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_beat(input logic [7:0] d, input logic l);
    int waited;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      stalls++;
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check_eq("beat_accept_timeout", 64'(in_ready), 64'd1);
    end else begin
      @(posedge clk);
      #1;
      model_accept(d, l);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    sb    = {};
    m_acc = '0;
    m_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    apply_reset();

    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_data",  64'(out_data),  64'd0);
    check_eq("rst_out_keep",  64'(out_keep),  64'd0);
    check_eq("rst_out_last",  64'(out_last),  64'd0);
    check_eq("rst_in_ready",  64'(in_ready),  64'd1);

    // Full word, one-cycle latency after the fourth beat.
    w0 = words;
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    send_beat(8'h33, 1'b0);
    check_eq("s1_no_early_valid", 64'(out_valid), 64'd0);
    send_beat(8'h44, 1'b0);
    check_eq("s1_latency_valid", 64'(out_valid), 64'd1);
    check_eq("s1_data_direct", 64'(out_data), 64'h44332211);
    idle(3);
    check_eq("s1_word_count", 64'(words - w0), 64'd1);

    // Short packet flushed by in_last.
    w0 = words;
    send_beat(8'hAA, 1'b0);
    send_beat(8'hBB, 1'b1);
    idle(3);
    check_eq("s2_word_count", 64'(words - w0), 64'd1);

    // Backpressure: word held stable while the sink stalls.
    w0 = words;
    out_ready = 1'b0;
    send_beat(8'hAA, 1'b0);
    send_beat(8'hBB, 1'b0);
    send_beat(8'hCC, 1'b0);
    send_beat(8'hDD, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("s3_in_ready_low",  64'(in_ready),  64'd0);
      check_eq("s3_hold_valid",    64'(out_valid), 64'd1);
      check_eq("s3_hold_data",     64'(out_data),  64'hDDCCBBAA);
      check_eq("s3_hold_keep",     64'(out_keep),  64'hF);
      check_eq("s3_hold_last",     64'(out_last),  64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    idle(1);
    check_eq("s3_drained_valid", 64'(out_valid), 64'd0);
    idle(2);
    check_eq("s3_word_count", 64'(words - w0), 64'd1);

    // Streaming: 16 back-to-back beats, no input stall.
    w0     = words;
    stalls = 0;
    for (int i = 0; i < 16; i++) begin
      send_beat(8'(i), 1'b0);
    end
    idle(3);
    check_eq("s4_stalls", 64'(stalls), 64'd0);
    check_eq("s4_word_count", 64'(words - w0), 64'd4);

    // Reset mid-word discards the partial word.
    w0 = words;
    send_beat(8'h01, 1'b0);
    send_beat(8'h02, 1'b0);
    apply_reset();
    check_eq("s5_in_ready_post_rst", 64'(in_ready), 64'd1);
    send_beat(8'h55, 1'b0);
    send_beat(8'h66, 1'b0);
    send_beat(8'h77, 1'b0);
    send_beat(8'h88, 1'b0);
    idle(3);
    check_eq("s5_word_count", 64'(words - w0), 64'd1);

    // in_last on the final lane: exactly one full word.
    w0 = words;
    send_beat(8'hC1, 1'b0);
    send_beat(8'hC2, 1'b0);
    send_beat(8'hC3, 1'b0);
    send_beat(8'hC4, 1'b1);
    check_eq("s6_keep_direct", 64'(out_keep), 64'hF);
    check_eq("s6_last_direct", 64'(out_last), 64'd1);
    idle(4);
    check_eq("s6_word_count", 64'(words - w0), 64'd1);
    check_eq("s6_idle_after", 64'(out_valid), 64'd0);

    check_eq("sb_drain", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
